// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared glyphs and digit-select helper for the seven-segment scan driver
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments ordered g..a
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Active-low enable for select position pos while digit idx is being scanned
  function automatic logic digit_sel_n(input int unsigned idx, input int unsigned pos);
    return (idx != pos);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low seven-segment glyph
module seg7_hex_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed seven-segment driver with lap, flash, blanking and guard
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_BITS  = 16,
  parameter int BLINK_BITS = 25,
  parameter int GUARD_CYC  = 8,
  parameter logic [NUM_DIGITS-1:0] DP_MASK = 4'b1010
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    lapState,
  input  logic                    flashState,
  input  logic                    lzb_en,
  output logic [6:0]              sevenSeg,
  output logic [NUM_DIGITS-1:0]   displaySelect,
  output logic                    decimal,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_BITS-1:0] GUARD_VAL = SCAN_BITS'(GUARD_CYC);

  logic [SCAN_BITS-1:0]    r_scan_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [BLINK_BITS-1:0]   r_blink_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_dp;
  logic                    r_frame_start;

  logic                    w_slot_end;
  logic                    w_frame_wrap;
  logic                    w_guard;
  logic                    w_dark;
  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [NUM_DIGITS-1:0]   w_lead_zero;

  assign w_slot_end   = &r_scan_cnt;
  assign w_frame_wrap = w_slot_end && (r_digit_idx == '0);
  assign w_guard      = (r_scan_cnt < GUARD_VAL);
  assign w_nibble     = r_shadow[{r_digit_idx, 2'b00} +: 4];

  // w_lead_zero[i]: shadow digit i and every digit above it are zero
  always_comb begin
    w_lead_zero = '0;
    w_lead_zero[NUM_DIGITS-1] = (r_shadow[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_lead_zero[i] = w_lead_zero[i+1] && (r_shadow[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    w_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_sel[i] = digit_sel_n(32'(r_digit_idx), i);
    end
  end

  assign w_dark = (lzb_en && (r_digit_idx != '0) && w_lead_zero[r_digit_idx]) ||
                  (flashState && r_blink_cnt[BLINK_BITS-1]);

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt    <= '0;
      r_digit_idx   <= LAST_IDX;
      r_blink_cnt   <= '0;
      r_shadow      <= '0;
      r_seg         <= SEG_BLANK;
      r_sel         <= '1;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_scan_cnt    <= r_scan_cnt + 1'b1;
      r_blink_cnt   <= r_blink_cnt + 1'b1;
      r_frame_start <= w_frame_wrap;
      if (w_slot_end) begin
        r_digit_idx <= (r_digit_idx == '0) ? LAST_IDX : r_digit_idx - 1'b1;
      end
      // Snapshot only on frame boundaries so a frame is never torn
      if (w_frame_wrap && !lapState) begin
        r_shadow <= digits;
      end
      if (w_guard) begin
        r_seg <= SEG_BLANK;
        r_sel <= '1;
        r_dp  <= 1'b1;
      end else begin
        r_sel <= w_sel;
        r_seg <= w_dark ? SEG_BLANK : w_glyph;
        r_dp  <= w_dark ? 1'b1 : ~DP_MASK[r_digit_idx];
      end
    end
  end

  assign sevenSeg      = r_seg;
  assign displaySelect = r_sel;
  assign decimal       = r_dp;
  assign frame_start   = r_frame_start;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - randomized self-checking bench for seg_scan_display
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int SLOT = 16;
  localparam int FRAME = SLOT * ND;
  localparam int BLINK = 256;
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic        lapState = 1'b0;
  logic        flashState = 1'b0;
  logic        lzb_en = 1'b0;
  logic [6:0]  sevenSeg;
  logic [3:0]  displaySelect;
  logic        decimal;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;
  bit run_checks = 1'b0;

  // Reference model state: cycles since reset release and the latched snapshot
  int          m_k;
  logic [15:0] m_shadow;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_dp;
  logic        exp_fs;
  logic [6:0]  glyph [16];

  seg_scan_display #(
    .NUM_DIGITS (4),
    .SCAN_BITS  (4),
    .BLINK_BITS (8),
    .GUARD_CYC  (2),
    .DP_MASK    (4'b1010)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .digits        (digits),
    .lapState      (lapState),
    .flashState    (flashState),
    .lzb_en        (lzb_en),
    .sevenSeg      (sevenSeg),
    .displaySelect (displaySelect),
    .decimal       (decimal),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
    glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
    glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
    glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h k=%0d t=%0t", tag, obs, exp, m_k, $time);
    end
  endtask

  always @(posedge clk) begin
    int pos, dig, nib;
    bit dark;
    if (reset) begin
      m_k = 0;
      m_shadow = 16'h0000;
      exp_seg = 7'h7F;
      exp_sel = 4'hF;
      exp_dp  = 1'b1;
      exp_fs  = 1'b0;
    end else begin
      pos = m_k % SLOT;
      dig = (ND - 1) - ((m_k / SLOT) % ND);
      if (pos < GUARD) begin
        exp_seg = 7'h7F;
        exp_sel = 4'hF;
        exp_dp  = 1'b1;
      end else begin
        exp_sel = 4'hF & ~(4'h1 << dig);
        nib  = int'(m_shadow[dig*4 +: 4]);
        dark = (lzb_en && dig > 0 && (m_shadow >> (4 * dig)) == 16'h0000) ||
               (flashState && (m_k % BLINK) >= BLINK / 2);
        exp_seg = dark ? 7'h7F : glyph[nib];
        exp_dp  = dark ? 1'b1 : !(dig == 1 || dig == 3);
      end
      exp_fs = (m_k % FRAME == FRAME - 1);
      if (m_k % FRAME == FRAME - 1 && !lapState) m_shadow = digits;
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (run_checks) begin
      check("sevenSeg", 32'(sevenSeg), 32'(exp_seg));
      check("displaySelect", 32'(displaySelect), 32'(exp_sel));
      check("decimal", 32'(decimal), 32'(exp_dp));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [15:0] d, input bit lap, input bit fl, input bit lz);
    digits = d;
    lapState = lap;
    flashState = fl;
    lzb_en = lz;
  endtask

  initial begin
    bit found;
    logic [15:0] rd;
    @(posedge clk);
    run_checks = 1'b1;
    run(3);
    reset = 1'b0;

    set_in(16'h1234, 0, 0, 0);
    run(3 * FRAME);
    set_in(16'h5678, 1, 0, 0);
    run(2 * FRAME + 20);
    set_in(16'h5678, 0, 0, 0);
    run(2 * FRAME);
    set_in(16'h0040, 0, 0, 1);
    run(3 * FRAME);
    set_in(16'h0000, 0, 0, 1);
    run(2 * FRAME);
    set_in(16'hABCF, 0, 1, 0);
    run(3 * BLINK);
    set_in(16'h9DE0, 0, 0, 0);
    run(2 * FRAME);

    found = 1'b0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(negedge clk);
      if (((m_k / SLOT) % ND) == 1 && (m_k % SLOT) == 5) found = 1'b1;
    end
    check("reset_slot_found", 32'(found), 32'd1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(2 * FRAME);

    for (int it = 0; it < 30; it++) begin
      for (int n = 0; n < ND; n++) begin
        rd[n*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      set_in(rd, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'($urandom));
      run($urandom_range(30, 400));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
      end
    end

    run(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
